// File: rtl/spi_sram_master.sv
// spi_sram_master: SPI mode-0 master issuing single-byte READ (0x03) / WRITE (0x02) to a serial SRAM.
// Optional macro SPI_SRAM_MASTER_SEQ_EN keeps cs_n low after a read so an address+1 read skips cmd/addr.
module spi_sram_master #(
  parameter int ADDR_BYTES     = 3,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);
  // state | meaning
  // IDLE  | cs_n high, req_ready high, waiting for a request
  // CMD   | shifting out the 8-bit command
  // ADDR  | shifting out the address, MSB first
  // DATA  | shifting write data out / read data in
  // CSH   | cs_n high recovery, CS_HIGH_CYCLES long
  // SEQ   | cs_n held low after a read, awaiting a sequential read (SEQ_EN builds only)

  localparam int AW = 8 * ADDR_BYTES;
  localparam int NB = 16 + AW;
  localparam int CW = $clog2(((CS_HIGH_CYCLES > AW) ? CS_HIGH_CYCLES : AW) + 1);
  localparam logic [CW-1:0] CNT_BYTE = CW'(7);
  localparam logic [CW-1:0] CNT_ADDR = CW'(AW - 1);
  localparam logic [CW-1:0] CNT_CSH  = CW'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    CSH
`ifdef SPI_SRAM_MASTER_SEQ_EN
    , SEQ
`endif
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [NB-2:0]  tx_sr;
  logic [7:0]     rx_sr;
  logic           wr_q;
  logic           ready_q;
  logic           seq_block;

`ifdef SPI_SRAM_MASTER_SEQ_EN
  logic [AW-1:0]  last_addr;
  logic           seq_hit;

  assign seq_hit   = !req_wr && (req_addr[AW-1:0] == last_addr + AW'(1));
  // a non-sequential request in SEQ must not be taken: it first closes the burst via CSH
  assign seq_block = (state == SEQ) && req_valid && !seq_hit;
`else
  assign seq_block = 1'b0;
`endif

  assign req_ready = ready_q && !seq_block;

  always_ff @(posedge clk) begin
    rsp_valid <= 1'b0;
    if (rst) begin
      state     <= CSH;
      cnt       <= CNT_CSH;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ready_q   <= 1'b0;
      rsp_rdata <= 8'h00;
      tx_sr     <= '0;
      rx_sr     <= 8'h00;
      wr_q      <= 1'b0;
`ifdef SPI_SRAM_MASTER_SEQ_EN
      last_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state   <= CMD;
            cnt     <= CNT_BYTE;
            cs_n    <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= req_wr;
            mosi    <= 1'b0;
            tx_sr   <= {6'b000001, ~req_wr, req_addr[AW-1:0], (req_wr ? req_wdata : 8'h00)};
`ifdef SPI_SRAM_MASTER_SEQ_EN
            last_addr <= req_addr[AW-1:0];
`endif
          end
        end
        CMD, ADDR, DATA: begin
          if (!sclk) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
          end else begin
            sclk  <= 1'b0;
            mosi  <= tx_sr[NB-2];
            tx_sr <= {tx_sr[NB-3:0], 1'b0};
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (state == CMD) begin
              state <= ADDR;
              cnt   <= CNT_ADDR;
            end else if (state == ADDR) begin
              state <= DATA;
              cnt   <= CNT_BYTE;
            end else begin
              mosi      <= 1'b0;
              rsp_valid <= 1'b1;
              if (!wr_q) rsp_rdata <= rx_sr;
`ifdef SPI_SRAM_MASTER_SEQ_EN
              if (!wr_q) begin
                state   <= SEQ;
                ready_q <= 1'b1;
              end else begin
                state <= CSH;
                cs_n  <= 1'b1;
                cnt   <= CNT_CSH;
              end
`else
              state <= CSH;
              cs_n  <= 1'b1;
              cnt   <= CNT_CSH;
`endif
            end
          end
        end
        CSH: begin
          if (cnt == '0) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SPI_SRAM_MASTER_SEQ_EN
        SEQ: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            if (seq_hit) begin
              state     <= DATA;
              cnt       <= CNT_BYTE;
              wr_q      <= 1'b0;
              mosi      <= 1'b0;
              tx_sr     <= '0;
              last_addr <= req_addr[AW-1:0];
            end else begin
              state <= CSH;
              cs_n  <= 1'b1;
              cnt   <= CNT_CSH;
            end
          end
        end
`endif
        default: begin
          state   <= CSH;
          cs_n    <= 1'b1;
          sclk    <= 1'b0;
          mosi    <= 1'b0;
          ready_q <= 1'b0;
          cnt     <= CNT_CSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_master.sv
// tb_spi_sram_master: random and directed transactions against a behavioural serial-SRAM model.
// Define SPI_SRAM_MASTER_SEQ_EN for both bench and RTL to exercise sequential-read bursts.
module tb_spi_sram_master;
  localparam int CSH = 2;
`ifdef SPI_SRAM_MASTER_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        req_ready, rsp_valid, cs_n, sclk, mosi;
  logic [7:0]  rsp_rdata;
  logic        miso = 1'b0;

  logic        req_valid2 = 1'b0;
  logic        req_ready2, rsp_valid2, cs_n2, sclk2, mosi2;
  logic [7:0]  rsp_rdata2;
  logic        miso2 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_sram_master #(.ADDR_BYTES(3), .CS_HIGH_CYCLES(CSH)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_sram_master #(.ADDR_BYTES(2), .CS_HIGH_CYCLES(CSH)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_wr(1'b0),
    .req_addr(24'h00BEEF), .req_wdata(8'h00), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .cs_n(cs_n2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Power-on SRAM contents: a fixed function of the address
  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // ---------------- serial SRAM model on the ADDR_BYTES=3 bus ----------------
  bit          cap_q[$];
  logic [7:0]  sram_wr [logic [23:0]];
  logic [7:0]  s_cmd = 8'h00;
  logic [23:0] s_addr = 24'h0;
  logic        sclk_seen = 1'b0;
  int          s_n, s_idx;
  logic [7:0]  s_byte;

  function automatic logic [7:0] cap_byte(input int s);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r = {r[6:0], cap_q[s+i]};
    return r;
  endfunction

  function automatic logic [7:0] sram_rd(input logic [23:0] a);
    return sram_wr.exists(a) ? sram_wr[a] : init_byte(a);
  endfunction

  always @(posedge sclk or negedge sclk or negedge cs_n) begin
    if (sclk && !sclk_seen) begin
      cap_q.push_back(mosi);
      s_n = cap_q.size();
      if (s_n <= 8) s_cmd = {s_cmd[6:0], mosi};
      else if (s_n <= 32) s_addr = {s_addr[22:0], mosi};
      else if (s_cmd == 8'h02 && (s_n - 32) % 8 == 0)
        sram_wr[s_addr + 24'((s_n - 40) / 8)] = cap_byte(s_n - 8);
    end else if (!sclk && !sclk_seen) begin
      cap_q.delete();
      s_cmd  = 8'h00;
      s_addr = 24'h0;
    end
    if (!sclk) begin
      s_n = cap_q.size();
      if (s_n >= 32 && s_cmd == 8'h03) begin
        s_idx  = s_n - 32;
        s_byte = sram_rd(s_addr + 24'(s_idx / 8));
        miso   = s_byte[7 - (s_idx % 8)];
      end else begin
        miso = 1'b0;
      end
    end
    sclk_seen = sclk;
  end

  // ---------------- minimal read-only SRAM model on the ADDR_BYTES=2 bus ----------------
  int          s2_n = 0;
  logic [31:0] s2_cap = 32'h0;
  logic [7:0]  s2_byte;

  always @(posedge sclk2 or negedge cs_n2) begin
    if (!sclk2) begin
      s2_n   = 0;
      s2_cap = 32'h0;
    end else begin
      s2_cap = {s2_cap[30:0], mosi2};
      s2_n++;
    end
  end

  always @(negedge sclk2) begin
    s2_byte = init_byte(24'h00BEEF);
    miso2   = (s2_n >= 24 && s2_n < 32) ? s2_byte[7 - (s2_n - 24)] : 1'b0;
  end

  // With cs_n high the bus must be quiet
  always @(negedge clk) begin
    if (cs_n === 1'b1) begin
      check_val("idle_sclk", 32'(sclk), 0);
      check_val("idle_mosi", 32'(mosi), 0);
    end
    if (cs_n2 === 1'b1) check_val("idle_sclk2", 32'(sclk2), 0);
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_wr [logic [23:0]];
  bit          seq_open = 1'b0;
  logic [23:0] last_a = 24'h0;
  logic [7:0]  last_rd = 8'h00;

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_wr.exists(a) ? ref_wr[a] : init_byte(a);
  endfunction

  task automatic scramble_req();
    req_valid = 1'($urandom);
    req_wr    = 1'($urandom);
    req_addr  = 24'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic do_txn(input bit wr, input logic [23:0] a, input logic [7:0] wd);
    bit hit;
    bit blocked;
    int k, csh_seen, prev_n, exp_cs;
    hit     = SEQ_EN && seq_open && !wr && (a == last_a + 24'd1);
    blocked = SEQ_EN && seq_open && !hit;
    prev_n  = cap_q.size();
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    #1;
    if (blocked) check_val("seq_block_ready", 32'(req_ready), 0);
    k = 0; csh_seen = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
      if (cs_n) csh_seen++;
    end
    check_val("ready_wait", 32'(k < 200), 1);
    if (blocked) check_val("seq_csh_len", 32'(csh_seen >= CSH), 1);
    @(posedge clk); #1;
    check_val("acc_cs_low", 32'(cs_n), 0);
    scramble_req();
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (!rsp_valid) scramble_req();
    end
    req_valid = 1'b0;
    check_val("latency", k, hit ? 16 : 80);
    if (hit) begin
      check_val("seq_bits", cap_q.size(), prev_n + 8);
    end else begin
      check_val("nbits", cap_q.size(), 40);
      check_val("cmd", 32'(cap_byte(0)), wr ? 32'h02 : 32'h03);
      check_val("addr", {8'h00, cap_byte(8), cap_byte(16), cap_byte(24)}, 32'(a));
      if (wr) check_val("wdata", 32'(cap_byte(32)), 32'(wd));
    end
    if (!wr) begin
      check_val("rdata", 32'(rsp_rdata), 32'(ref_rd(a)));
      last_rd = ref_rd(a);
    end else begin
      ref_wr[a] = wd;
    end
    exp_cs = (SEQ_EN && !wr) ? 0 : 1;
    for (int i = 0; i < CSH; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        check_val("rsp_pulse", 32'(rsp_valid), 0);
      end
      check_val("end_cs", 32'(cs_n), exp_cs);
      check_val("end_ready", 32'(req_ready), 32'(exp_cs == 0));
    end
    check_val("rdata_hold", 32'(rsp_rdata), 32'(last_rd));
    seq_open = SEQ_EN && !wr;
    last_a   = a;
  endtask

  // Reset lands while sclk is high, mid-address
  task automatic abort_read(input logic [23:0] a);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    k = 0;
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    check_val("abort_pre_sclk", 32'(sclk), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("abort_cs", 32'(cs_n), 1);
    check_val("abort_sclk", 32'(sclk), 0);
    check_val("abort_ready", 32'(req_ready), 0);
    rst = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
      check_val("abort_no_rsp", 32'(rsp_valid), 0);
    end
    check_val("abort_ready_delay", k, CSH);
    seq_open = 1'b0;
    last_rd  = 8'h00;
  endtask

  initial begin
    int k;
    logic [31:0] c2;
    bit          wr;
    logic [23:0] a;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cs", 32'(cs_n), 1);
    check_val("rst_sclk", 32'(sclk), 0);
    check_val("rst_mosi", 32'(mosi), 0);
    check_val("rst_ready", 32'(req_ready), 0);
    check_val("rst_rsp", 32'(rsp_valid), 0);
    check_val("rst_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    check_val("rst_ready_delay", k, CSH);

    abort_read(24'h000400);
    check_val("abort_rdata", 32'(rsp_rdata), 0);

    do_txn(1'b1, 24'h001234, 8'hA5);
    do_txn(1'b0, 24'h001234, 8'h00);
    do_txn(1'b0, 24'h00FFFF, 8'h00);
    do_txn(1'b0, 24'h010000, 8'h00);
    do_txn(1'b0, 24'h000010, 8'h00);
    do_txn(1'b1, 24'h000011, 8'h3C);
    do_txn(1'b0, 24'h000011, 8'h00);
    do_txn(1'b0, 24'hFFFFFF, 8'h00);
    do_txn(1'b0, 24'h000000, 8'h00);

    for (int i = 0; i < 30; i++) begin
      wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       a = last_a + 24'd1;
        1:       a = 24'h001230 + 24'($urandom_range(0, 7));
        default: a = 24'($urandom);
      endcase
      do_txn(wr, a, 8'($urandom));
    end

    @(negedge clk);
    req_valid2 = 1'b1;
    k = 0;
    while (!req_ready2 && k < 50) begin @(negedge clk); k++; end
    check_val("ready2_wait", 32'(k < 50), 1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    k = 0;
    while (!rsp_valid2 && k < 200) begin @(posedge clk); #1; k++; end
    check_val("latency2", k, 64);
    check_val("nbits2", s2_n, 32);
    c2 = s2_cap;
    check_val("hdr2", 32'(c2[31:8]), 32'h0003BEEF);
    check_val("rdata2", 32'(rsp_rdata2), 32'(init_byte(24'h00BEEF)));
    @(posedge clk); #1;
    check_val("cs2_end", 32'(cs_n2), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
